// File: rtl/baseerat_mux_arb_if.sv
// rtl/baseerat_mux_arb_if.sv - two-source / one-sink stream bundle for the round-robin mux arbiter
// The master modport is the arbiter's view; slave is the view of whatever surrounds it.
interface baseerat_mux_arb_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  s0_valid;
  logic                  s0_ready;
  logic [DATA_WIDTH-1:0] s0_data;
  logic                  s0_last;

  logic                  s1_valid;
  logic                  s1_ready;
  logic [DATA_WIDTH-1:0] s1_data;
  logic                  s1_last;

  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_last;

  logic [1:0]            grant;
  logic                  busy;

  modport master (
    input  s0_valid, s0_data, s0_last,
    output s0_ready,
    input  s1_valid, s1_data, s1_last,
    output s1_ready,
    output m_valid, m_data, m_last,
    input  m_ready,
    output grant, busy
  );

  modport slave (
    output s0_valid, s0_data, s0_last,
    input  s0_ready,
    output s1_valid, s1_data, s1_last,
    input  s1_ready,
    input  m_valid, m_data, m_last,
    output m_ready,
    input  grant, busy
  );
endinterface

// File: rtl/baseerat_mux_arb.sv
// rtl/baseerat_mux_arb.sv - round-robin, packet-locked 2:1 stream arbiter with one registered output stage
// Grant state drives the data mux select; a beat is accepted only while its source holds the grant.
module baseerat_mux_arb #(
  parameter int DATA_WIDTH = 16,
  parameter bit PKT_MODE   = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  baseerat_mux_arb_if.master   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    G0   = 2'd1,
    G1   = 2'd2
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic                  rr_src1;
  logic                  m_valid_q;
  logic [DATA_WIDTH-1:0] m_data_q;
  logic                  m_last_q;

  logic                  out_free;
  logic                  sel_valid;
  logic                  sel_last;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  other_valid;
  logic                  accept;
  logic                  end_grant;

  // Output slot can take a new beat when empty or being drained this cycle.
  assign out_free = !m_valid_q || bus.m_ready;

  always_comb begin
    sel_valid   = bus.s0_valid;
    sel_last    = bus.s0_last;
    sel_data    = bus.s0_data;
    other_valid = bus.s1_valid;
    if (state == G1) begin
      sel_valid   = bus.s1_valid;
      sel_last    = bus.s1_last;
      sel_data    = bus.s1_data;
      other_valid = bus.s0_valid;
    end
  end

  assign accept    = (state != IDLE) && sel_valid && out_free;
  assign end_grant = accept && (!PKT_MODE || sel_last);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (bus.s0_valid && bus.s1_valid) begin
          state_nxt = rr_src1 ? G0 : G1;
        end else if (bus.s0_valid) begin
          state_nxt = G0;
        end else if (bus.s1_valid) begin
          state_nxt = G1;
        end
      end
      G0, G1: begin
        if (end_grant) begin
          // Hand straight over to a waiting peer so back-to-back packets see no bubble.
          if (other_valid) begin
            state_nxt = (state == G0) ? G1 : G0;
          end else if (!PKT_MODE && sel_valid && !sel_last) begin
            state_nxt = state;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      rr_src1   <= 1'b1;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_last_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        rr_src1   <= (state == G1);
        m_valid_q <= 1'b1;
        m_data_q  <= sel_data;
        m_last_q  <= sel_last;
      end else if (bus.m_ready) begin
        m_valid_q <= 1'b0;
      end
    end
  end

  assign bus.s0_ready = (state == G0) && out_free;
  assign bus.s1_ready = (state == G1) && out_free;
  assign bus.m_valid  = m_valid_q;
  assign bus.m_data   = m_data_q;
  assign bus.m_last   = m_last_q;
  assign bus.grant    = {state == G1, state == G0};
  assign bus.busy     = (state != IDLE) || m_valid_q;

endmodule
